// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial driver that feeds the bidirectional
// shift register: FSM state encoding, direction codes and default width.
package shift_reg_pkg;

  // Driver FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Direction codes; they match the downstream register's mode input
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Default word length, equal to the downstream register length
  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/shift_reg_serial_driver_if.sv
// Handshake and serial-line bundle between a word producer, the serial
// driver and the downstream shift register.
interface shift_reg_serial_driver_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             mode;
  logic             dr;
  logic             dl;
  logic             busy;
  logic             frame_done;

  // Word producer side
  modport master (
    output in_valid, in_data, in_dir,
    input  in_ready, mode, dr, dl, busy, frame_done
  );

  // Serial driver side
  modport slave (
    input  in_valid, in_data, in_dir,
    output in_ready, mode, dr, dl, busy, frame_done
  );

endinterface

// File: rtl/shift_reg_serial_driver.sv
// Serialises a parallel word onto the mode/Dr/Dl inputs of a free-running
// bidirectional shift register, one bit per clock, and pulses frame_done in
// the cycle the register holds the whole word. The register shifts every
// clock, so the serial lines are driven (with FILL) even when idle.
module shift_reg_serial_driver
  import shift_reg_pkg::*;
#(
  parameter int   WIDTH = DEF_WIDTH,
  parameter logic FILL  = 1'b0,
  localparam int  CNT_W = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shift_reg_serial_driver_if.slave bus
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_dir;
  logic             r_mode;
  logic             r_dr;
  logic             r_dl;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load_bit;
  logic             w_next_bit;

  // Bit sent in cycle k: LSB-first for right shift, MSB-first for left shift
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic             dir,
                                    input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    if (dir == DIR_LEFT) begin
      idx = CNT_W'(WIDTH - 1) - k;
    end else begin
      idx = k;
    end
    return word[idx];
  endfunction

  // Handshake only succeeds when ready, which is high in IDLE and DONE only
  assign w_accept   = bus.in_valid && r_ready;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  // First bit of the incoming word goes out together with the new mode
  assign w_load_bit = pick_bit(bus.in_data, bus.in_dir, {CNT_W{1'b0}});
  assign w_next_bit = pick_bit(r_word, r_dir, w_cnt_nxt);

  // Driver FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_word  <= {WIDTH{1'b0}};
      r_dir   <= DIR_RIGHT;
      r_mode  <= DIR_RIGHT;
      r_dr    <= FILL;
      r_dl    <= FILL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else if (w_accept) begin
      // Load from IDLE or directly from DONE (back-to-back words)
      r_state <= SHIFT;
      r_cnt   <= {CNT_W{1'b0}};
      r_word  <= bus.in_data;
      r_dir   <= bus.in_dir;
      r_mode  <= bus.in_dir;
      r_dr    <= (bus.in_dir == DIR_RIGHT) ? w_load_bit : FILL;
      r_dl    <= (bus.in_dir == DIR_LEFT)  ? w_load_bit : FILL;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dr    <= FILL;
          r_dl    <= FILL;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        SHIFT: begin
          if (w_last) begin
            // Register samples the last bit on this edge: word complete next cycle
            r_state <= DONE;
            r_dr    <= FILL;
            r_dl    <= FILL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_dr    <= (r_dir == DIR_RIGHT) ? w_next_bit : FILL;
            r_dl    <= (r_dir == DIR_LEFT)  ? w_next_bit : FILL;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_dr    <= FILL;
          r_dl    <= FILL;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {CNT_W{1'b0}};
          r_dr    <= FILL;
          r_dl    <= FILL;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_ready;
  assign bus.mode       = r_mode;
  assign bus.dr         = r_dr;
  assign bus.dl         = r_dl;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule
